rotary_quad_decoder: RTL and testbench

ROTARY_QUAD_DECODER -- requirements
Module: rotary_quad_decoder

---
 rtl/rotary_quad_decoder.sv | 119 +++++++++++
 tb/tb_rotary_quad_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rotary_quad_decoder.sv
// rtl/rotary_quad_decoder.sv - quadrature encoder decoder with synchroniser, debounce and signed position count
module rotary_quad_decoder #(
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [CNT_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
    localparam logic [4:0] INIT_LAST = 5'(DEB_CYCLES + 2);

    logic [1:0] a_sync, b_sync;
    logic       a_s, b_s;
    logic [3:0] cnt_a, cnt_b;
    logic       filt_a, filt_b;
    logic       acc_a, acc_b;
    logic       filt_a_nxt, filt_b_nxt;
    logic [0:0] state;
    logic [4:0] init_cnt;
    logic [1:0] prev;
    logic [1:0] cur;
    logic [1:0] delta;
    logic       is_cw, is_ccw, is_bad;

    // Gray position index: 00->0, 01->1, 11->2, 10->3, so CW is +1 mod 4
    function automatic logic [1:0] gray_idx(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    assign a_s = a_sync[1];
    assign b_s = b_sync[1];

    always_comb begin
        acc_a      = (a_s != filt_a) && (cnt_a == DEB_LAST);
        acc_b      = (b_s != filt_b) && (cnt_b == DEB_LAST);
        filt_a_nxt = acc_a ? a_s : filt_a;
        filt_b_nxt = acc_b ? b_s : filt_b;
        cur        = {filt_a, filt_b};
        delta      = gray_idx(cur) - gray_idx(prev);
        is_cw      = (delta == 2'd1);
        is_ccw     = (delta == 2'd3);
        is_bad     = (delta == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
            cnt_a  <= 4'd0;
            cnt_b  <= 4'd0;
            filt_a <= 1'b0;
            filt_b <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], enc_a};
            b_sync <= {b_sync[0], enc_b};
            cnt_a  <= (a_s == filt_a || acc_a) ? 4'd0 : cnt_a + 4'd1;
            cnt_b  <= (b_s == filt_b || acc_b) ? 4'd0 : cnt_b + 4'd1;
            filt_a <= filt_a_nxt;
            filt_b <= filt_b_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= 5'd0;
            prev     <= 2'b00;
            pos      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 5'd1;
                    // Reference takes the value the filter is settling to this edge
                    if ((acc_a && acc_b) || init_cnt == INIT_LAST) begin
                        prev  <= {filt_a_nxt, filt_b_nxt};
                        state <= ST_RUN;
                    end
                end
                default: begin
                    prev <= cur;
                    if (ena) begin
                        if (is_cw) begin
                            pos  <= pos + CNT_W'(1);
                            dir  <= 1'b1;
                            step <= 1'b1;
                        end else if (is_ccw) begin
                            pos  <= pos - CNT_W'(1);
                            dir  <= 1'b0;
                            step <= 1'b1;
                        end else if (is_bad) begin
                            err <= 1'b1;
                        end
                    end
                end
            endcase
            if (clear) begin
                pos <= '0;
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb/tb_rotary_quad_decoder.sv - scoreboard bench for rotary_quad_decoder
module tb_rotary_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       enc_a = 1'b1;
    logic       enc_b = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] pos;
    logic       dir;
    logic       step;
    logic       err;

    rotary_quad_decoder #(.CNT_W(8), .DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .clear (clear),
        .pos   (pos),
        .dir   (dir),
        .step  (step),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] pos;
        logic       dir;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         steps_seen = 0;
    int         steps_pushed = 0;
    logic [7:0] model_pos = 8'd0;
    logic       prev_step = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && step) begin
            exp_t e;
            steps_seen++;
            chk("step_not_back_to_back", {31'd0, prev_step}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step at cycle %0d pos %0h required no step", cyc, pos);
            end else begin
                e = sb.pop_front();
                chk("step_pos", {24'd0, pos}, {24'd0, e.pos});
                chk("step_dir", {31'd0, dir}, {31'd0, e.dir});
                chk("step_cycle", cyc, e.cyc);
            end
        end
        prev_step = step;
    end

    // kind: 0 = no step expected, 1 = CW, 2 = CCW
    task automatic move(input logic a, input logic b, input int kind, input int hold);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
        if (kind != 0 && ena) begin
            model_pos = (kind == 1) ? model_pos + 8'd1 : model_pos - 8'd1;
            sb.push_back('{model_pos, (kind == 1), cyc + 7});
            steps_pushed++;
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_pos = 8'd0;
    endtask

    logic [1:0] cw_seq [4];

    initial begin
        cw_seq[0] = 2'b00;
        cw_seq[1] = 2'b01;
        cw_seq[2] = 2'b11;
        cw_seq[3] = 2'b10;

        // Reset with pins at 11, then hold
        repeat (3) @(negedge clk);
        chk("reset_pos", {24'd0, pos}, 32'd0);
        chk("reset_dir", {31'd0, dir}, 32'd0);
        chk("reset_step", {31'd0, step}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("pins11_pos", {24'd0, pos}, 32'd0);
        chk("pins11_err", {31'd0, err}, 32'd0);

        // Re-reset at 00 for the quadrature tests
        rst_n = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_pos = 8'd0;
        repeat (20) @(negedge clk);

        move(1'b0, 1'b1, 1, 10);
        move(1'b1, 1'b1, 1, 10);
        move(1'b1, 1'b0, 1, 10);
        move(1'b0, 1'b0, 1, 10);
        chk("cw4_pos", {24'd0, pos}, 32'd4);
        chk("cw4_dir", {31'd0, dir}, 32'd1);
        chk("cw4_err", {31'd0, err}, 32'd0);

        pulse_clear();
        chk("clear_pos", {24'd0, pos}, 32'd0);
        move(1'b1, 1'b0, 2, 10);
        chk("ccw_wrap_pos", {24'd0, pos}, 32'hFF);
        chk("ccw_wrap_dir", {31'd0, dir}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            logic [1:0] nx;
            nx = cw_seq[i % 4];
            move(nx[1], nx[0], 1, 8);
        end
        chk("cw256_pos", {24'd0, pos}, 32'hFF);
        chk("cw256_dir", {31'd0, dir}, 32'd1);

        // Three-cycle glitch on A must be filtered out
        @(negedge clk);
        enc_a = 1'b0;
        repeat (3) @(negedge clk);
        enc_a = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_pos", {24'd0, pos}, 32'hFF);
        chk("glitch_err", {31'd0, err}, 32'd0);
        move(1'b0, 1'b1, 0, 10);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_pos", {24'd0, pos}, 32'hFF);
        pulse_clear();
        chk("clear_err", {31'd0, err}, 32'd0);
        chk("clear_pos2", {24'd0, pos}, 32'd0);

        ena = 1'b0;
        move(1'b1, 1'b1, 0, 10);
        move(1'b1, 1'b0, 0, 10);
        ena = 1'b1;
        move(1'b0, 1'b0, 1, 10);
        chk("ena_pos", {24'd0, pos}, 32'd1);
        chk("ena_dir", {31'd0, dir}, 32'd1);

        // Reset three cycles after a pin change discards the pending step
        move(1'b0, 1'b1, 0, 3);
        rst_n = 1'b0;
        #1;
        chk("midreset_pos", {24'd0, pos}, 32'd0);
        chk("midreset_step", {31'd0, step}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_pos = 8'd0;
        repeat (20) @(negedge clk);
        chk("postreset_pos", {24'd0, pos}, 32'd0);
        chk("postreset_err", {31'd0, err}, 32'd0);
        move(1'b1, 1'b1, 1, 10);
        chk("reinit_pos", {24'd0, pos}, 32'd1);
        chk("reinit_err", {31'd0, err}, 32'd0);

        repeat (5) @(negedge clk);
        chk("queue_empty", sb.size(), 32'd0);
        chk("step_count", steps_seen, steps_pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
